risc_sequencer: RTL and testbench

//  Instruction-cycle controller for the 8-bit-bus RISC core. Sequences the 13-bit PC counter, IR, ACC and data bus.

---
 rtl/risc_sequencer_pkg.sv | 46 ++++
 rtl/risc_sequencer_if.sv | 34 +++
 rtl/risc_sequencer_strobe_decode.sv | 63 ++++++
 rtl/risc_sequencer.sv | 80 ++++++++
 tb/tb_risc_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/risc_sequencer_pkg.sv
// Shared types for the RISC instruction-cycle sequencer:
// opcodes, state encoding and the strobe-vector bit map.
package risc_sequencer_pkg;

  localparam logic [2:0] OP_HLT  = 3'd0;
  localparam logic [2:0] OP_SKZ  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_ANDD = 3'd3;
  localparam logic [2:0] OP_XORR = 3'd4;
  localparam logic [2:0] OP_LDA  = 3'd5;
  localparam logic [2:0] OP_STO  = 3'd6;
  localparam logic [2:0] OP_JMP  = 3'd7;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_S0     = 4'd1,
    ST_S1     = 4'd2,
    ST_S2     = 4'd3,
    ST_S3     = 4'd4,
    ST_S4     = 4'd5,
    ST_S5     = 4'd6,
    ST_S6     = 4'd7,
    ST_S7     = 4'd8,
    ST_HALTED = 4'd9
  } state_t;

  localparam int SB_INC_PC   = 0;
  localparam int SB_LOAD_PC  = 1;
  localparam int SB_RD       = 2;
  localparam int SB_WR       = 3;
  localparam int SB_LOAD_IR  = 4;
  localparam int SB_LOAD_ACC = 5;
  localparam int SB_DATACTL  = 6;
  localparam int SB_HALT     = 7;
  localparam int SB_W        = 8;

  typedef logic [SB_W-1:0] strobe_t;

  function automatic strobe_t sb_bit(input int idx);
    strobe_t v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/risc_sequencer_if.sv
// Control bundle between the sequencer and the core datapath.
// master = sequencer, slave = datapath / test driver.
interface risc_sequencer_if #(
  parameter int OPW   = 3,
  parameter int CNT_W = 16
);
  logic             ena;
  logic [OPW-1:0]   opcode;
  logic             zero;
  logic             inc_pc;
  logic             load_pc;
  logic             rd;
  logic             wr;
  logic             load_ir;
  logic             load_acc;
  logic             datactl_ena;
  logic             halt;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  ena, opcode, zero,
    output inc_pc, load_pc, rd, wr,
    output load_ir, load_acc, datactl_ena,
    output halt, state, retired
  );

  modport slave (
    output ena, opcode, zero,
    input  inc_pc, load_pc, rd, wr,
    input  load_ir, load_acc, datactl_ena,
    input  halt, state, retired
  );
endinterface

// File: rtl/risc_sequencer_strobe_decode.sv
// Pure decode of (state, op_q, skip_q) into the strobe vector.
// Inputs are all registered, so outputs carry no input paths.
module risc_sequencer_strobe_decode
  import risc_sequencer_pkg::*;
#(
  parameter int OPW = 3
) (
  input  state_t         state,
  input  logic [OPW-1:0] op_q,
  input  logic           skip_q,
  output strobe_t        sb
);

  logic is_alu;
  logic is_sto;
  logic is_jmp;
  logic is_skz;

  assign is_alu = (op_q == OPW'(OP_ADD))
               || (op_q == OPW'(OP_ANDD))
               || (op_q == OPW'(OP_XORR))
               || (op_q == OPW'(OP_LDA));
  assign is_sto = (op_q == OPW'(OP_STO));
  assign is_jmp = (op_q == OPW'(OP_JMP));
  assign is_skz = (op_q == OPW'(OP_SKZ));

  always_comb begin
    sb = '0;
    unique case (state)
      ST_S0, ST_S1: begin
        sb = sb_bit(SB_RD)
           | sb_bit(SB_LOAD_IR)
           | sb_bit(SB_INC_PC);
      end
      ST_S4: begin
        unique case (1'b1)
          is_alu: sb = sb_bit(SB_RD);
          is_sto: sb = sb_bit(SB_DATACTL);
          is_jmp: sb = sb_bit(SB_LOAD_PC);
          is_skz: sb[SB_INC_PC] = skip_q;
          default: ;
        endcase
      end
      ST_S5: begin
        unique case (1'b1)
          is_alu: sb = sb_bit(SB_RD)
                     | sb_bit(SB_LOAD_ACC);
          is_sto: sb = sb_bit(SB_WR)
                     | sb_bit(SB_DATACTL);
          is_skz: sb[SB_INC_PC] = skip_q;
          default: ;
        endcase
      end
      // Hold the bus one cycle after wr falls.
      ST_S6: begin
        if (is_sto) sb = sb_bit(SB_DATACTL);
      end
      ST_HALTED: sb = sb_bit(SB_HALT);
      default: ;
    endcase
  end

endmodule

// File: rtl/risc_sequencer.sv
// Eight-state instruction-cycle controller for the 8-bit-bus
// RISC core: fetch hi/lo, decode, execute, writeback.
module risc_sequencer
  import risc_sequencer_pkg::*;
#(
  parameter int OPW      = 3,
  parameter int CNT_W    = 16,
  parameter bit AUTO_RUN = 1'b0
) (
  input logic             clock,
  input logic             rst,
  risc_sequencer_if.master bus
);

  state_t           state_q;
  state_t           state_d;
  logic [OPW-1:0]   op_q;
  logic             skip_q;
  logic [CNT_W-1:0] ret_q;
  logic             go;
  strobe_t          sb;

  assign go = bus.ena | AUTO_RUN;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      skip_q  <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_S2) op_q <= bus.opcode;
      if (state_q == ST_S3) skip_q <= bus.zero;
      if (state_q == ST_S7) ret_q <= ret_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (go) state_d = ST_S0;
      ST_S0:   state_d = ST_S1;
      ST_S1:   state_d = ST_S2;
      ST_S2:   state_d = ST_S3;
      // op_q was captured on the S2 edge, so it is valid here.
      ST_S3: begin
        if (op_q == OPW'(OP_HLT)) state_d = ST_HALTED;
        else                      state_d = ST_S4;
      end
      ST_S4:   state_d = ST_S5;
      ST_S5:   state_d = ST_S6;
      ST_S6:   state_d = ST_S7;
      ST_S7:   state_d = go ? ST_S0 : ST_IDLE;
      ST_HALTED: state_d = ST_HALTED;
      default: state_d = ST_IDLE;
    endcase
  end

  risc_sequencer_strobe_decode #(
    .OPW (OPW)
  ) u_dec (
    .state  (state_q),
    .op_q   (op_q),
    .skip_q (skip_q),
    .sb     (sb)
  );

  assign bus.inc_pc      = sb[SB_INC_PC];
  assign bus.load_pc     = sb[SB_LOAD_PC];
  assign bus.rd          = sb[SB_RD];
  assign bus.wr          = sb[SB_WR];
  assign bus.load_ir     = sb[SB_LOAD_IR];
  assign bus.load_acc    = sb[SB_LOAD_ACC];
  assign bus.datactl_ena = sb[SB_DATACTL];
  assign bus.halt        = sb[SB_HALT];
  assign bus.state       = state_q;
  assign bus.retired     = ret_q;

endmodule

// File: tb/tb_risc_sequencer.sv
// Scoreboard bench for risc_sequencer: driver queues the
// expected per-cycle state/strobes, a monitor compares them.
module tb_risc_sequencer;
  import risc_sequencer_pkg::*;

  typedef struct packed {
    logic        w;
    logic [3:0]  st;
    logic [7:0]  sb;
    logic [15:0] ret;
  } exp_t;

  logic clock;
  logic rst;
  logic rst_w;

  risc_sequencer_if #(.OPW(3), .CNT_W(16)) bus ();
  risc_sequencer_if #(.OPW(3), .CNT_W(4))  wbus ();

  risc_sequencer #(
    .OPW(3), .CNT_W(16), .AUTO_RUN(1'b0)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus.master)
  );

  risc_sequencer #(
    .OPW(3), .CNT_W(4), .AUTO_RUN(1'b1)
  ) dut_w (
    .clock (clock),
    .rst   (rst_w),
    .bus   (wbus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  exp_t q[$];
  logic [15:0] exp_ret;

  strobe_t act_sb;
  strobe_t act_wsb;

  always_comb begin
    act_sb = '0;
    act_sb[SB_INC_PC]   = bus.inc_pc;
    act_sb[SB_LOAD_PC]  = bus.load_pc;
    act_sb[SB_RD]       = bus.rd;
    act_sb[SB_WR]       = bus.wr;
    act_sb[SB_LOAD_IR]  = bus.load_ir;
    act_sb[SB_LOAD_ACC] = bus.load_acc;
    act_sb[SB_DATACTL]  = bus.datactl_ena;
    act_sb[SB_HALT]     = bus.halt;
  end

  always_comb begin
    act_wsb = '0;
    act_wsb[SB_INC_PC]   = wbus.inc_pc;
    act_wsb[SB_LOAD_PC]  = wbus.load_pc;
    act_wsb[SB_RD]       = wbus.rd;
    act_wsb[SB_WR]       = wbus.wr;
    act_wsb[SB_LOAD_IR]  = wbus.load_ir;
    act_wsb[SB_LOAD_ACC] = wbus.load_acc;
    act_wsb[SB_DATACTL]  = wbus.datactl_ena;
    act_wsb[SB_HALT]     = wbus.halt;
  end

  // Monitor: one expected item per sampled cycle.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = q.pop_front();
      a.w = e.w;
      if (e.w) begin
        a.st  = wbus.state;
        a.sb  = act_wsb;
        a.ret = 16'(wbus.retired);
      end else begin
        a.st  = bus.state;
        a.sb  = act_sb;
        a.ret = bus.retired;
      end
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL seq%0d t=%0t got st=%0d sb=%b ret=%0d want st=%0d sb=%b ret=%0d",
                 e.w, $time, a.st, a.sb, a.ret, e.st, e.sb, e.ret);
      end
    end
  end

  task automatic check(input string name,
                       input logic [27:0] act,
                       input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input state_t st, input strobe_t sb);
    exp_t e;
    @(posedge clock);
    #1;
    e.w = 1'b0;
    e.st = st;
    e.sb = sb;
    e.ret = exp_ret;
    q.push_back(e);
  endtask

  // Hand-written expected strobes per opcode and step.
  function automatic strobe_t row(input logic [2:0] op,
                                  input logic z,
                                  input int idx);
    strobe_t f;
    strobe_t r;
    logic alu;
    f = sb_bit(SB_RD) | sb_bit(SB_LOAD_IR) | sb_bit(SB_INC_PC);
    alu = (op == OP_ADD) || (op == OP_ANDD)
       || (op == OP_XORR) || (op == OP_LDA);
    r = '0;
    case (idx)
      0, 1: r = f;
      4: begin
        if (alu) r = sb_bit(SB_RD);
        else if (op == OP_STO) r = sb_bit(SB_DATACTL);
        else if (op == OP_JMP) r = sb_bit(SB_LOAD_PC);
        else if (op == OP_SKZ && z) r = sb_bit(SB_INC_PC);
      end
      5: begin
        if (alu) r = sb_bit(SB_RD) | sb_bit(SB_LOAD_ACC);
        else if (op == OP_STO) r = sb_bit(SB_WR) | sb_bit(SB_DATACTL);
        else if (op == OP_SKZ && z) r = sb_bit(SB_INC_PC);
      end
      6: if (op == OP_STO) r = sb_bit(SB_DATACTL);
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic run_instr(input logic [2:0] op,
                           input logic z,
                           input logic cont,
                           input bit abort);
    cyc(ST_S0, row(op, z, 0));
    cyc(ST_S1, row(op, z, 1));
    bus.opcode = ~op;
    cyc(ST_S2, row(op, z, 2));
    bus.opcode = op;
    bus.zero = ~z;
    cyc(ST_S3, row(op, z, 3));
    bus.opcode = ~op;
    bus.zero = z;
    if (op == OP_HLT) begin
      cyc(ST_HALTED, sb_bit(SB_HALT));
      bus.zero = ~z;
      return;
    end
    cyc(ST_S4, row(op, z, 4));
    bus.zero = ~z;
    bus.ena = cont;
    cyc(ST_S5, row(op, z, 5));
    if (abort) return;
    cyc(ST_S6, row(op, z, 6));
    cyc(ST_S7, row(op, z, 7));
    exp_ret = exp_ret + 16'd1;
  endtask

  initial begin
    exp_ret = '0;
    rst = 1'b1;
    rst_w = 1'b1;
    bus.ena = 1'b0;
    bus.opcode = 3'd3;
    bus.zero = 1'b0;
    wbus.ena = 1'b0;
    wbus.opcode = OP_LDA;
    wbus.zero = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check("reset", {bus.state, act_sb, bus.retired},
          {ST_IDLE, 8'h00, 16'h0000});
    rst = 1'b0;

    for (int i = 0; i < 10; i++) cyc(ST_IDLE, '0);
    bus.ena = 1'b1;

    run_instr(OP_LDA,  1'b0, 1'b1, 1'b0);
    run_instr(OP_SKZ,  1'b1, 1'b1, 1'b0);
    run_instr(OP_SKZ,  1'b0, 1'b1, 1'b0);
    run_instr(OP_STO,  1'b1, 1'b1, 1'b0);
    run_instr(OP_JMP,  1'b0, 1'b1, 1'b0);
    run_instr(OP_ANDD, 1'b1, 1'b1, 1'b0);
    run_instr(OP_XORR, 1'b0, 1'b1, 1'b0);
    run_instr(OP_ADD,  1'b0, 1'b0, 1'b0);
    cyc(ST_IDLE, '0);
    cyc(ST_IDLE, '0);

    @(negedge clock);
    #1;
    check("retired_pre", {12'h0, bus.retired}, 28'd8);
    rst = 1'b1;
    #1;
    check("rst_clear", {bus.state, act_sb, bus.retired},
          {ST_IDLE, 8'h00, 16'h0000});
    exp_ret = '0;
    bus.ena = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;

    run_instr(OP_ADD, 1'b0, 1'b1, 1'b1);
    @(negedge clock);
    #1;
    rst = 1'b1;
    #1;
    check("rst_in_s5", {bus.state, act_sb, bus.retired},
          {ST_IDLE, 8'h00, 16'h0000});
    @(posedge clock);
    #1;
    rst = 1'b0;

    run_instr(OP_HLT, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) begin
      bus.ena = ~bus.ena;
      cyc(ST_HALTED, sb_bit(SB_HALT));
    end
    @(negedge clock);
    #1;
    rst = 1'b1;
    #1;
    check("halt_clear", {bus.state, act_sb, bus.retired},
          {ST_IDLE, 8'h00, 16'h0000});
    bus.ena = 1'b0;
    @(posedge clock);
    #1;
    rst = 1'b0;

    @(posedge clock);
    #1;
    rst_w = 1'b0;
    for (int e = 1; e <= 137; e++) begin
      @(posedge clock);
      #1;
      if (e % 8 == 1) begin
        exp_t x;
        x.w = 1'b1;
        x.st = ST_S0;
        x.sb = sb_bit(SB_RD) | sb_bit(SB_LOAD_IR) | sb_bit(SB_INC_PC);
        x.ret = 16'(((e - 1) / 8) % 16);
        q.push_back(x);
      end
    end

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
